// File: rtl/amux_arb_pkg.sv
// Shared types and helpers for the analog mux bus arbiter.
//   state_t  : per-bus channel state (IDLE / CONNECT / BREAK)
//   BUS_A/B  : bit positions of each bus in two-bit per-bus vectors
//   rr_pick  : round-robin search over a request vector of up to 32 bits
package amux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONNECT = 2'd1,
        BREAK   = 2'd2
    } state_t;

    localparam int BUS_A = 0;
    localparam int BUS_B = 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping at n. ptr < n <= 32.
    function automatic pick_t rr_pick(input logic [31:0] req, input int ptr, input int n);
        pick_t r;
        int    idx;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if ((k < n) && !r.valid && req[idx]) begin
                r.valid = 1'b1;
                r.idx   = 32'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/amux_bus_channel.sv
// One analog mux bus: round-robin owner selection, break-before-make gap,
// and (with AMUX_HOLD_TIMEOUT_EN defined) forced revoke after MAX_HOLD
// cycles of ownership while another requester is waiting.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   amux_en     : global enable; low releases the bus
//   elig        : requesters currently allowed onto this bus
//   grant       : combinational one-hot of the requester being granted this cycle
//   en          : registered switch enables, one-hot or zero
//   owner       : current owner index, valid while busy
//   busy        : channel is in CONNECT
//   preempt     : one-cycle pulse after a forced revoke (0 without the feature)
module amux_bus_channel
    import amux_arb_pkg::*;
#(
    parameter int N          = 8,
    parameter int BBM_CYCLES = 4,
    parameter int MAX_HOLD   = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 amux_en,
    input  logic [N-1:0]         elig,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 preempt
);

    localparam int            IW       = $clog2(N);
    localparam int            BW       = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [BW-1:0] BBM_LOAD = BW'(BBM_CYCLES - 1);
    localparam logic [N-1:0]  ONE      = N'(1);

    state_t         state, state_nxt;
    logic [IW-1:0]  owner_nxt, ptr, ptr_nxt;
    logic [BW-1:0]  bbm, bbm_nxt;
    logic [N-1:0]   en_nxt;
    logic           busy_nxt;
    logic           revoke;
    pick_t          pick;

    assign pick  = rr_pick(32'(elig), int'(ptr), N);
    assign grant = (state == IDLE && amux_en && pick.valid) ? (ONE << IW'(pick.idx)) : '0;

`ifdef AMUX_HOLD_TIMEOUT_EN
    localparam int            HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold;
    logic          others;

    assign others = |(elig & ~(ONE << owner));
    // Only revoke an owner that would otherwise keep the bus.
    assign revoke = (state == CONNECT) && amux_en && elig[owner] && (hold == HOLD_TOP) && others;

    // Counter sits at 0 outside CONNECT, so it starts from 0 on every new grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold    <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= revoke;
            if (state != CONNECT)
                hold <= '0;
            else if (hold != HOLD_TOP)
                hold <= hold + 1'b1;
        end
    end
`else
    assign revoke  = 1'b0;
    assign preempt = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            bbm   <= '0;
            en    <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            bbm   <= bbm_nxt;
            en    <= en_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        bbm_nxt   = bbm;
        case (state)
            IDLE: begin
                if (amux_en && pick.valid) begin
                    state_nxt = CONNECT;
                    owner_nxt = IW'(pick.idx);
                end
            end
            CONNECT: begin
                if (!amux_en || !elig[owner] || revoke) begin
                    state_nxt = BREAK;
                    bbm_nxt   = BBM_LOAD;
                    ptr_nxt   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
                end
            end
            BREAK: begin
                if (bbm == '0)
                    state_nxt = IDLE;
                else
                    bbm_nxt = bbm - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: enables follow the next state so they are registered.
    always_comb begin
        busy_nxt = (state_nxt == CONNECT);
        en_nxt   = busy_nxt ? (ONE << owner_nxt) : '0;
    end

endmodule

// File: rtl/amux_bus_arbiter.sv
// Arbiter for the two pad-ring analog mux buses (AMUXBUS_A, AMUXBUS_B).
// Each bus has a round-robin, break-before-make channel; this level keeps a
// requester from ever being on both buses. Optional feature macro:
// AMUX_HOLD_TIMEOUT_EN (forced revoke after MAX_HOLD cycles under contention).
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   amux_en          : global enable; low releases both buses
//   req_a, req_b     : level requests per requester for each bus
//   en_a, en_b       : switch enables, one-hot or zero, never overlapping
//   owner_a, owner_b : owner index, valid while the matching busy is high
//   busy_a, busy_b   : bus is connected
//   preempt          : forced-revoke pulses, bit0 = A, bit1 = B
module amux_bus_arbiter
    import amux_arb_pkg::*;
#(
    parameter int N          = 8,
    parameter int BBM_CYCLES = 4,
    parameter int MAX_HOLD   = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 amux_en,
    input  logic [N-1:0]         req_a,
    input  logic [N-1:0]         req_b,
    output logic [N-1:0]         en_a,
    output logic [N-1:0]         en_b,
    output logic [$clog2(N)-1:0] owner_a,
    output logic [$clog2(N)-1:0] owner_b,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic [1:0]           preempt
);

    logic [N-1:0] elig_a, elig_b, grant_a, grant_b;
    logic         pre_a, pre_b;

    // A yields only to a requester already on B; B also yields to whoever
    // A is granting right now, which makes A win a simultaneous first grant.
    assign elig_a = req_a & ~en_b;
    assign elig_b = req_b & ~en_a & ~grant_a;

    amux_bus_channel #(.N(N), .BBM_CYCLES(BBM_CYCLES), .MAX_HOLD(MAX_HOLD)) u_chan_a (
        .clk     (clk),
        .resetn  (resetn),
        .amux_en (amux_en),
        .elig    (elig_a),
        .grant   (grant_a),
        .en      (en_a),
        .owner   (owner_a),
        .busy    (busy_a),
        .preempt (pre_a)
    );

    amux_bus_channel #(.N(N), .BBM_CYCLES(BBM_CYCLES), .MAX_HOLD(MAX_HOLD)) u_chan_b (
        .clk     (clk),
        .resetn  (resetn),
        .amux_en (amux_en),
        .elig    (elig_b),
        .grant   (grant_b),
        .en      (en_b),
        .owner   (owner_b),
        .busy    (busy_b),
        .preempt (pre_b)
    );

    // grant_b only matters inside channel B; fold it into nothing visible.
    logic unused_grant_b;
    assign unused_grant_b = ^grant_b;

    assign preempt[BUS_A] = pre_a;
    assign preempt[BUS_B] = pre_b;

endmodule

// File: tb/tb_amux_bus_arbiter.sv
module tb_amux_bus_arbiter;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          resetn;
    logic          amux_en;
    logic [N-1:0]  req_a, req_b;
    logic [N-1:0]  en_a, en_b;
    logic [IW-1:0] owner_a, owner_b;
    logic          busy_a, busy_b;
    logic [1:0]    preempt;

    int n_checks = 0;
    int n_fail   = 0;

    amux_bus_arbiter #(.N(N), .BBM_CYCLES(4), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .amux_en (amux_en),
        .req_a   (req_a),
        .req_b   (req_b),
        .en_a    (en_a),
        .en_b    (en_b),
        .owner_a (owner_a),
        .owner_b (owner_b),
        .busy_a  (busy_a),
        .busy_b  (busy_b),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bus invariants sampled on every falling edge while out of reset.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            n_checks++;
            assert ($onehot0(en_a) && $onehot0(en_b) && ((en_a & en_b) == '0)) else begin
                n_fail++;
                $error("FAIL invariant observed en_a=%h en_b=%h expected onehot0 and disjoint", en_a, en_b);
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        amux_en = 1'b0;
        req_a   = '0;
        req_b   = '0;
        tick(2);
        chk("rst_en_a", 32'(en_a), 32'h0);
        chk("rst_en_b", 32'(en_b), 32'h0);
        chk("rst_busy", {30'd0, busy_b, busy_a}, 32'h0);
        chk("rst_owner", {26'd0, owner_b, owner_a}, 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        resetn  = 1'b1;
        amux_en = 1'b1;
        tick(1);

        // Single request: enable one cycle later
        req_a = 8'h04;
        chk("single_pre_en_a", 32'(en_a), 32'h0);
        tick(1);
        chk("single_en_a", 32'(en_a), 32'h04);
        chk("single_owner_a", 32'(owner_a), 32'd2);
        chk("single_busy_a", 32'(busy_a), 32'd1);
        chk("single_en_b", 32'(en_b), 32'h0);
        req_a = 8'h00;
        tick(1);
        chk("single_release", {31'd0, busy_a}, 32'h0);
        tick(5);

        // Round robin: pointer is 3, so 0x05 wraps to bit0 first
        req_a = 8'h05;
        tick(1);
        chk("rr_first_owner", 32'(en_a), 32'h01);
        req_a = 8'h04;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rr_bbm_gap", 32'(en_a), 32'h0);
        end
        tick(1);
        chk("rr_second_owner", 32'(en_a), 32'h04);
        chk("rr_second_owner_idx", 32'(owner_a), 32'd2);
        req_a = 8'h05;
        tick(3);
        chk("rr_bit0_waits", 32'(en_a), 32'h04);
        req_a = 8'h01;
        tick(1);
        chk("rr_bit2_drop", 32'(en_a), 32'h0);
        tick(5);
        chk("rr_bit0_after_gap", 32'(en_a), 32'h01);
        req_a = 8'h00;
        tick(6);

        // Cross-bus conflict: A wins, B takes over once A lets go
        req_a = 8'h08;
        req_b = 8'h08;
        tick(1);
        chk("xbus_en_a", 32'(en_a), 32'h08);
        chk("xbus_en_b_held_off", 32'(en_b), 32'h0);
        tick(2);
        chk("xbus_busy_b_still_0", 32'(busy_b), 32'd0);
        req_a = 8'h00;
        tick(1);
        chk("xbus_a_dropped", 32'(en_a), 32'h0);
        chk("xbus_b_not_yet", 32'(en_b), 32'h0);
        tick(1);
        chk("xbus_b_granted", 32'(en_b), 32'h08);
        chk("xbus_owner_b", 32'(owner_b), 32'd3);

        // Global disable with both buses connected
        req_a = 8'h10;
        tick(6);
        chk("both_en_a", 32'(en_a), 32'h10);
        chk("both_en_b", 32'(en_b), 32'h08);
        amux_en = 1'b0;
        tick(1);
        chk("dis_en", {en_b, en_a}, 32'h0);
        chk("dis_busy", {30'd0, busy_b, busy_a}, 32'h0);
        amux_en = 1'b1;
        tick(1);
        chk("dis_break_holds", {en_b, en_a}, 32'h0);

        // Async reset mid-BREAK
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_break_outputs", {en_b, en_a}, 32'h0);
        tick(1);
        resetn = 1'b1;
        tick(1);
        chk("arst_regrant_a", 32'(en_a), 32'h10);
        chk("arst_regrant_b", 32'(en_b), 32'h08);

        // Async reset mid-cycle while connected: clears without a clock edge
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_conn_en", {en_b, en_a}, 32'h0);
        chk("arst_conn_busy", {30'd0, busy_b, busy_a}, 32'h0);
        chk("arst_conn_owner", {26'd0, owner_b, owner_a}, 32'h0);

        // Pointers back at 0; same-cycle tie: A takes 0, B moves on to 1
        req_a = 8'h01;
        req_b = 8'h03;
        tick(1);
        resetn = 1'b1;
        tick(1);
        chk("tie_en_a", 32'(en_a), 32'h01);
        chk("tie_en_b", 32'(en_b), 32'h02);
        chk("tie_owner_b", 32'(owner_b), 32'd1);

        // Hold timeout
        resetn = 1'b0;
        req_a  = 8'h03;
        req_b  = 8'h00;
        tick(1);
        resetn = 1'b1;
        tick(1);
        chk("hold_first_owner", 32'(en_a), 32'h01);
`ifdef AMUX_HOLD_TIMEOUT_EN
        tick(15);
        chk("hold_before_limit", 32'(en_a), 32'h01);
        chk("hold_no_preempt_yet", 32'(preempt), 32'h0);
        tick(1);
        chk("hold_revoked", 32'(en_a), 32'h0);
        chk("hold_preempt_pulse", 32'(preempt), 32'h1);
        tick(1);
        chk("hold_preempt_one_cycle", 32'(preempt), 32'h0);
        tick(3);
        chk("hold_gap", 32'(en_a), 32'h0);
        tick(1);
        chk("hold_next_owner", 32'(en_a), 32'h02);
        chk("hold_next_owner_idx", 32'(owner_a), 32'd1);
`else
        for (int i = 0; i < 4; i++) begin
            tick(10);
            chk("hold_indefinite", 32'(en_a), 32'h01);
            chk("hold_preempt_zero", 32'(preempt), 32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
